// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall bus, younger-stage flush and EX branch redirect,
// with a pending state that holds a redirect across an outstanding icache miss.
module pipe_ctrl #(
    parameter int CNT_W  = 32,
    parameter int RCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stallreq_if,
    input  logic              i_stallreq_id,
    input  logic              i_stallreq_mem,
    input  logic              i_branch_req_ex,
    input  logic [31:0]       i_branch_target_ex,
    output logic [5:0]        o_stall,
    output logic              o_flush,
    output logic              o_redirect_valid,
    output logic [31:0]       o_redirect_target,
    output logic              o_pending,
    output logic [CNT_W-1:0]  o_stall_cycles,
    output logic [RCNT_W-1:0] o_redirect_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_tgt_q;
    logic                w_tgt_load;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [RCNT_W-1:0]   r_redirect_count;
    logic [5:0]          w_stall_full;
    logic [5:0]          w_stall_no_id;

    // Full priority view, and the view that disregards a wrong-path load-use hazard.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves a latch.
        w_stall_full  = STALL_NONE;
        w_stall_no_id = STALL_NONE;
        if (i_stallreq_mem) begin
            w_stall_full  = STALL_MEM;
            w_stall_no_id = STALL_MEM;
        end else if (i_stallreq_id) begin
            w_stall_full  = STALL_ID;
            w_stall_no_id = i_stallreq_if ? STALL_IF : STALL_NONE;
        end else if (i_stallreq_if) begin
            w_stall_full  = STALL_IF;
            w_stall_no_id = STALL_IF;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_tgt_load        = 1'b0;
        o_stall           = STALL_NONE;
        o_flush           = 1'b0;
        o_redirect_valid  = 1'b0;
        o_redirect_target = 32'h0;
        o_pending         = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    o_redirect_target = i_branch_target_ex;
                    o_stall           = w_stall_full;
                    if (i_branch_req_ex && !i_stallreq_mem) begin
                        o_flush = 1'b1;
                        if (i_stallreq_if) begin
                            o_stall     = STALL_IF;
                            w_tgt_load  = 1'b1;
                            w_state_nxt = PENDING;
                        end else begin
                            o_stall          = STALL_NONE;
                            o_redirect_valid = 1'b1;
                        end
                    end
                end
                PENDING: begin
                    o_pending         = 1'b1;
                    o_flush           = 1'b1;
                    o_redirect_target = r_tgt_q;
                    o_stall           = w_stall_no_id;
                    if (!i_stallreq_if && !i_stallreq_mem) begin
                        o_redirect_valid = 1'b1;
                        w_state_nxt      = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state          <= IDLE;
            r_tgt_q          <= 32'h0;
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tgt_load)
                r_tgt_q <= i_branch_target_ex;
            if (o_stall[0] && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (o_redirect_valid)
                r_redirect_count <= r_redirect_count + RCNT_W'(1);
        end
    end

    assign o_stall_cycles   = r_stall_cycles;
    assign o_redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a narrow stall counter build makes saturation reachable.
module tb_pipe_ctrl;

    localparam int CNT_W  = 4;
    localparam int RCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_stallreq_if, i_stallreq_id, i_stallreq_mem, i_branch_req_ex;
    logic [31:0]       i_branch_target_ex;
    logic [5:0]        o_stall;
    logic              o_flush, o_redirect_valid, o_pending;
    logic [31:0]       o_redirect_target;
    logic [CNT_W-1:0]  o_stall_cycles;
    logic [RCNT_W-1:0] o_redirect_count;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.CNT_W(CNT_W), .RCNT_W(RCNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_stallreq_if      (i_stallreq_if),
        .i_stallreq_id      (i_stallreq_id),
        .i_stallreq_mem     (i_stallreq_mem),
        .i_branch_req_ex    (i_branch_req_ex),
        .i_branch_target_ex (i_branch_target_ex),
        .o_stall            (o_stall),
        .o_flush            (o_flush),
        .o_redirect_valid   (o_redirect_valid),
        .o_redirect_target  (o_redirect_target),
        .o_pending          (o_pending),
        .o_stall_cycles     (o_stall_cycles),
        .o_redirect_count   (o_redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs shortly after a rising edge and let combinational outputs settle.
    task automatic drive(input logic r, input logic s_if, input logic s_id, input logic s_mem,
                         input logic br, input logic [31:0] tgt);
        rst                = r;
        i_stallreq_if      = s_if;
        i_stallreq_id      = s_id;
        i_stallreq_mem     = s_mem;
        i_branch_req_ex    = br;
        i_branch_target_ex = tgt;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 32'h0);
        tick();
        // Outputs forced low during reset even with requests active.
        drive(1, 1, 1, 1, 1, 32'hABCD_0000);
        check("rst_stall", {26'h0, o_stall}, 32'h0);
        check("rst_flush", {31'h0, o_flush}, 32'h0);
        check("rst_rv", {31'h0, o_redirect_valid}, 32'h0);
        check("rst_tgt", o_redirect_target, 32'h0);
        check("rst_pend", {31'h0, o_pending}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("rst_scnt", {28'h0, o_stall_cycles}, 32'h0);
        check("rst_rcnt", {16'h0, o_redirect_count}, 32'h0);

        // Stall priority
        drive(0, 1, 1, 1, 0, 32'h0);
        check("prio_mem", {26'h0, o_stall}, 32'h1F);
        tick();
        drive(0, 1, 1, 0, 0, 32'h0);
        check("prio_id", {26'h0, o_stall}, 32'h07);
        tick();
        drive(0, 1, 0, 0, 0, 32'h0);
        check("prio_if", {26'h0, o_stall}, 32'h03);
        check("prio_if_flush", {31'h0, o_flush}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("prio_none", {26'h0, o_stall}, 32'h00);
        tick();
        check("prio_scnt", {28'h0, o_stall_cycles}, 32'd3);

        // Immediate branch, load-use ignored
        drive(0, 0, 1, 0, 1, 32'h0000_1040);
        check("imm_rv", {31'h0, o_redirect_valid}, 32'h1);
        check("imm_tgt", o_redirect_target, 32'h0000_1040);
        check("imm_flush", {31'h0, o_flush}, 32'h1);
        check("imm_stall", {26'h0, o_stall}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("imm_rcnt", {16'h0, o_redirect_count}, 32'd1);
        check("imm_pend", {31'h0, o_pending}, 32'h0);

        // Pending redirect across an icache miss
        drive(0, 1, 0, 0, 1, 32'h0000_2000);
        check("pnd_c1_flush", {31'h0, o_flush}, 32'h1);
        check("pnd_c1_stall", {26'h0, o_stall}, 32'h03);
        check("pnd_c1_rv", {31'h0, o_redirect_valid}, 32'h0);
        tick();
        for (int c = 2; c <= 4; c++) begin
            drive(0, 1, c[0], 0, 1, 32'h0000_DEAD);
            check($sformatf("pnd_c%0d_pend", c), {31'h0, o_pending}, 32'h1);
            check($sformatf("pnd_c%0d_flush", c), {31'h0, o_flush}, 32'h1);
            check($sformatf("pnd_c%0d_stall", c), {26'h0, o_stall}, 32'h03);
            check($sformatf("pnd_c%0d_tgt", c), o_redirect_target, 32'h0000_2000);
            check($sformatf("pnd_c%0d_rv", c), {31'h0, o_redirect_valid}, 32'h0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 32'h0000_DEAD);
        check("pnd_exit_rv", {31'h0, o_redirect_valid}, 32'h1);
        check("pnd_exit_tgt", o_redirect_target, 32'h0000_2000);
        tick();
        check("pnd_after_pend", {31'h0, o_pending}, 32'h0);
        check("pnd_rcnt", {16'h0, o_redirect_count}, 32'd2);
        check("pnd_scnt", {28'h0, o_stall_cycles}, 32'd7);

        // Mem-blocked branch, held in EX
        for (int c = 1; c <= 2; c++) begin
            drive(0, 0, 0, 1, 1, 32'h0000_4000);
            check($sformatf("memb_c%0d_stall", c), {26'h0, o_stall}, 32'h1F);
            check($sformatf("memb_c%0d_rv", c), {31'h0, o_redirect_valid}, 32'h0);
            check($sformatf("memb_c%0d_flush", c), {31'h0, o_flush}, 32'h0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 32'h0000_4000);
        check("memb_c3_rv", {31'h0, o_redirect_valid}, 32'h1);
        check("memb_c3_tgt", o_redirect_target, 32'h0000_4000);
        check("memb_c3_stall", {26'h0, o_stall}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("memb_rcnt", {16'h0, o_redirect_count}, 32'd3);
        check("memb_scnt", {28'h0, o_stall_cycles}, 32'd9);

        // PENDING exit waits for mem as well as IF
        drive(0, 1, 0, 0, 1, 32'h0000_5000);
        tick();
        drive(0, 0, 0, 1, 0, 32'h0);
        check("pmem_rv", {31'h0, o_redirect_valid}, 32'h0);
        check("pmem_stall", {26'h0, o_stall}, 32'h1F);
        check("pmem_pend", {31'h0, o_pending}, 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("pmem_exit_rv", {31'h0, o_redirect_valid}, 32'h1);
        check("pmem_exit_tgt", o_redirect_target, 32'h0000_5000);
        tick();
        check("pmem_rcnt", {16'h0, o_redirect_count}, 32'd4);
        check("pmem_scnt", {28'h0, o_stall_cycles}, 32'd11);

        // Reset while PENDING drops the latched redirect
        drive(0, 1, 0, 0, 1, 32'h0000_3000);
        tick();
        check("rstp_pend_in", {31'h0, o_pending}, 32'h1);
        drive(1, 0, 0, 0, 0, 32'h0);
        check("rstp_pend_rst", {31'h0, o_pending}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("rstp_rv", {31'h0, o_redirect_valid}, 32'h0);
        check("rstp_pend", {31'h0, o_pending}, 32'h0);
        check("rstp_flush", {31'h0, o_flush}, 32'h0);
        check("rstp_scnt", {28'h0, o_stall_cycles}, 32'h0);
        check("rstp_rcnt", {16'h0, o_redirect_count}, 32'h0);

        // Stall counter saturation
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 0, 1, 0, 32'h0);
            tick();
        end
        check("sat_scnt", {28'h0, o_stall_cycles}, 32'hF);
        drive(0, 0, 0, 1, 0, 32'h0);
        tick();
        check("sat_hold", {28'h0, o_stall_cycles}, 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
